// File: rtl/rom_scan_reader.sv
// Scan sequencer in front of a rom_AxB ROM: walks a block of words from a base
// address and streams the captured data out over valid/ready with a running checksum.
module rom_scan_reader #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  input  logic          abort,
  output logic [AW-1:0] rom_address,
  output logic          rom_read_one,
  output logic          rom_read_two,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, OUTPUT, FIN} state_t;

  localparam int            CW      = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [CW-1:0] rd_cnt;
  logic [AW-1:0] addr_q;
  logic [AW:0]   remaining;
  logic [DW-1:0] data_q;
  logic [DW-1:0] csum_q;
  logic          hs;
  logic          rd_last;

  assign hs      = (state == OUTPUT) && out_ready;
  assign rd_last = (rd_cnt == RD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_count == '0) ? FIN : SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (rd_last) state_nxt = OUTPUT;
      OUTPUT:  if (hs) state_nxt = (remaining == CNT_ONE) ? FIN : SETUP;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort overrides everything, including a start seen in IDLE
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      addr_q    <= '0;
      remaining <= '0;
      data_q    <= '0;
      csum_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            csum_q <= '0;
            if (word_count != '0) begin
              addr_q    <= base_addr;
              remaining <= word_count;
            end
          end
        end
        SETUP: rd_cnt <= '0;
        STROBE: begin
          rd_cnt <= rd_cnt + CW'(1);
          if (rd_last) data_q <= rom_data;
        end
        OUTPUT: begin
          // a handshake coinciding with abort still counts toward the checksum
          if (hs) begin
            csum_q    <= csum_q + data_q;
            remaining <= remaining - CNT_ONE;
            if (remaining != CNT_ONE) addr_q <= addr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_address  = addr_q;
    rom_read_one = (state == STROBE);
    rom_read_two = (state == STROBE);
    out_data     = data_q;
    out_valid    = (state == OUTPUT);
    out_last     = (state == OUTPUT) && (remaining == CNT_ONE);
    busy         = (state == SETUP) || (state == STROBE) || (state == OUTPUT);
    done         = (state == FIN);
    checksum     = csum_q;
  end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Bench for rom_scan_reader: two instances (RD_CYCLES 1 and 3) against an
// arithmetic model of the scan (word i = (base+i) ^ 8'h5A, checksum = sum mod 256).
module tb_rom_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s  [2];
  logic [7:0] base_s   [2];
  logic [8:0] wc_s     [2];
  logic       abort_s  [2];
  logic [7:0] addr_s   [2];
  logic       rd1_s    [2];
  logic       rd2_s    [2];
  logic [7:0] rdata_s  [2];
  logic [7:0] odata_s  [2];
  logic       ovalid_s [2];
  logic       oready_s [2];
  logic       olast_s  [2];
  logic       busy_s   [2];
  logic       done_s   [2];
  logic [7:0] csum_s   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata_s[0] = (rd1_s[0] & rd2_s[0]) ? (addr_s[0] ^ 8'h5A) : 8'h00;
  assign rdata_s[1] = (rd1_s[1] & rd2_s[1]) ? (addr_s[1] ^ 8'h5A) : 8'h00;

  rom_scan_reader #(.AW(8), .DW(8), .RD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .base_addr(base_s[0]),
    .word_count(wc_s[0]), .abort(abort_s[0]), .rom_address(addr_s[0]),
    .rom_read_one(rd1_s[0]), .rom_read_two(rd2_s[0]), .rom_data(rdata_s[0]),
    .out_data(odata_s[0]), .out_valid(ovalid_s[0]), .out_ready(oready_s[0]),
    .out_last(olast_s[0]), .busy(busy_s[0]), .done(done_s[0]), .checksum(csum_s[0])
  );

  rom_scan_reader #(.AW(8), .DW(8), .RD_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .base_addr(base_s[1]),
    .word_count(wc_s[1]), .abort(abort_s[1]), .rom_address(addr_s[1]),
    .rom_read_one(rd1_s[1]), .rom_read_two(rd2_s[1]), .rom_data(rdata_s[1]),
    .out_data(odata_s[1]), .out_valid(ovalid_s[1]), .out_ready(oready_s[1]),
    .out_last(olast_s[1]), .busy(busy_s[1]), .done(done_s[1]), .checksum(csum_s[1])
  );

  function automatic int rdc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] rom_word(input logic [7:0] base, input int idx);
    logic [7:0] a;
    a = base + 8'(idx);
    return a ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs(input int d);
    return {addr_s[d], rd1_s[d], rd2_s[d], odata_s[d], ovalid_s[d], olast_s[d],
            busy_s[d], done_s[d], csum_s[d]};
  endfunction

  // One complete scan; every handed-off word is checked against the model as it appears.
  task automatic scan(input int d, input logic [7:0] base, input logic [8:0] cnt,
                      input int ready_pct, input int stall_word, input bit poke,
                      output logic [7:0] first, output logic [7:0] lastw,
                      output logic [7:0] sum, output int lat, output int done_at);
    int nwords, stall, strobes, proto_bad, stable_bad;
    logic [7:0] exp_sum, pd, pa;
    logic pend, r;
    bit fin;
    nwords = 0; stall = 0; strobes = 0; proto_bad = 0; stable_bad = 0;
    exp_sum = '0; pd = '0; pa = '0; pend = 1'b0; fin = 1'b0;
    first = '0; lastw = '0; sum = '0; lat = -1; done_at = -1;
    @(negedge clk);
    start_s[d] = 1'b1; base_s[d] = base; wc_s[d] = cnt; oready_s[d] = 1'b0;
    for (int edges = 1; edges <= 3000 && !fin; edges++) begin
      @(negedge clk);
      start_s[d] = 1'b0;
      if (poke && edges == 3) begin
        start_s[d] = 1'b1; base_s[d] = 8'hEE; wc_s[d] = 9'd5;
      end
      if (rd1_s[d] !== rd2_s[d] || (rd1_s[d] && ovalid_s[d])) proto_bad++;
      if (rd1_s[d]) strobes++;
      if (pend && (odata_s[d] !== pd || addr_s[d] !== pa || !ovalid_s[d])) stable_bad++;
      if (ovalid_s[d] && lat < 0) lat = edges;
      if (ovalid_s[d] && nwords == stall_word && stall < 5) begin
        r = 1'b0; stall++;
      end else begin
        r = ($urandom_range(0, 99) < ready_pct);
      end
      oready_s[d] = r;
      if (ovalid_s[d] && r) begin
        check("word_data", odata_s[d], rom_word(base, nwords));
        check("word_last", olast_s[d], nwords == int'(cnt) - 1);
        if (nwords == 0) first = odata_s[d];
        lastw = odata_s[d];
        exp_sum = exp_sum + rom_word(base, nwords);
        nwords++;
        pend = 1'b0;
      end else begin
        pend = ovalid_s[d]; pd = odata_s[d]; pa = addr_s[d];
      end
      if (done_s[d]) begin
        fin = 1'b1; done_at = edges; sum = csum_s[d];
        check("busy_in_fin", busy_s[d], 0);
      end
    end
    oready_s[d] = 1'b0;
    if (!fin) check("scan_timeout", 0, 1);
    check("word_count", nwords, int'(cnt));
    check("strobe_cycles", strobes, int'(cnt) * rdc(d));
    check("checksum_model", sum, exp_sum);
    check("stall_stability", stable_bad, 0);
    check("strobe_protocol", proto_bad, 0);
  endtask

  typedef struct {
    int d; logic [7:0] base; logic [8:0] cnt; int stall; bit poke;
    logic [7:0] first; logic [7:0] lastw; logic [7:0] sum; int lat; int done_at;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f, l, s, exp8;
    int lat, dat, hs, seen;
    bit hit;

    tbl[0] = '{0, 8'h10, 9'd1,   -1, 1'b0, 8'h4A, 8'h4A, 8'h4A, 3, 4};
    tbl[1] = '{0, 8'hFE, 9'd4,   -1, 1'b1, 8'hA4, 8'h5B, 8'hFE, 3, 13};
    tbl[2] = '{0, 8'h20, 9'd3,    1, 1'b0, 8'h7A, 8'h78, 8'h6D, 3, 15};
    tbl[3] = '{0, 8'h00, 9'd0,   -1, 1'b0, 8'h00, 8'h00, 8'h00, -1, 1};
    tbl[4] = '{1, 8'h00, 9'd256, -1, 1'b0, 8'h5A, 8'hA5, 8'h80, 5, 1281};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; base_s[i] = '0; wc_s[i] = '0; abort_s[i] = 1'b0; oready_s[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("reset_outs_rd1", all_outs(0), 0);
    check("reset_outs_rd3", all_outs(1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      scan(tbl[i].d, tbl[i].base, tbl[i].cnt, 100, tbl[i].stall, tbl[i].poke, f, l, s, lat, dat);
      check($sformatf("tbl%0d_first", i), f, tbl[i].first);
      check($sformatf("tbl%0d_lastw", i), l, tbl[i].lastw);
      check($sformatf("tbl%0d_sum", i), s, tbl[i].sum);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_done_at", i), dat, tbl[i].done_at);
    end

    // abort in STROBE of word 3 of an 8-word scan
    @(negedge clk);
    start_s[0] = 1'b1; base_s[0] = 8'h30; wc_s[0] = 9'd8; oready_s[0] = 1'b1;
    hs = 0; hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      if (hs == 2 && rd1_s[0]) begin
        abort_s[0] = 1'b1; hit = 1'b1;
      end
      if (ovalid_s[0]) hs++;
    end
    check("abort_reached", hit, 1);
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort_busy", busy_s[0], 0);
    check("abort_strobe", rd1_s[0], 0);
    check("abort_valid", ovalid_s[0], 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_s[0] || busy_s[0]) seen++;
    end
    check("abort_no_done", seen, 0);
    exp8 = rom_word(8'h30, 0) + rom_word(8'h30, 1);
    check("abort_checksum", csum_s[0], exp8);

    // abort and start together in IDLE: start must be ignored
    @(negedge clk);
    start_s[0] = 1'b1; abort_s[0] = 1'b1; wc_s[0] = 9'd3;
    @(negedge clk);
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    seen = 0;
    repeat (6) begin
      if (busy_s[0] || rd1_s[0] || done_s[0]) seen++;
      @(negedge clk);
    end
    check("abort_start_idle", seen, 0);
    oready_s[0] = 1'b0;

    // asynchronous reset mid-scan
    @(negedge clk);
    start_s[1] = 1'b1; base_s[1] = 8'h40; wc_s[1] = 9'd100; oready_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_reset_busy", busy_s[1], 1);
    #2 rst_n = 1'b0;
    #1 check("reset_midscan", all_outs(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    oready_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", busy_s[1], 0);

    // randomized scans against the model
    for (int n = 0; n < 20; n++) begin
      int d, pct;
      logic [7:0] b;
      logic [8:0] c;
      d = int'($urandom_range(0, 1));
      pct = int'($urandom_range(30, 100));
      b = 8'($urandom);
      c = 9'($urandom_range(1, 24));
      scan(d, b, c, pct, -1, 1'b0, f, l, s, lat, dat);
      check("rand_first", f, rom_word(b, 0));
      check("rand_latency", lat, 2 + rdc(d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
